top_mips: RTL and testbench



---
 rtl/top_mips.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_top_mips.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_mips.sv
// ---------------------------------------------------------------------------
// top_mips -- minimal 3-stage MIPS-subset core (IF -> ID/EX -> WB).
//
// Holds a debug-loadable instruction memory, a 32-entry register file and one
// ALU. Data memory lives outside the core; load data arrives on i_data_mem and
// is captured when the LW passes through ID/EX.
//
// Ports:
//   i_clk                rising-edge clock
//   i_reset              asynchronous active-low reset
//   i_enable             1 = PC and pipeline advance, 0 = everything frozen
//   i_pc                 PC value forced while i_write = 1 (word index)
//   i_write              debug load: imem[i_address] <= i_instruction, PC <= i_pc
//   i_instruction        word written into instruction memory
//   i_address            instruction-memory word index for debug writes
//   i_data_mem           load data from external data memory (LW result)
//   i_address_read_debug register index for debug reads (optional build only)
//   o_instruction        imem[PC], combinational
//   o_pc                 current PC register
//   o_data_read_debug    last value written back into the register file, or
//                        reg[i_address_read_debug] in the optional build
//
// Build option:
//   MIPS_DEBUG_REGREAD_EN  when defined, adds i_address_read_debug and turns
//                          o_data_read_debug into a combinational register-file
//                          read port (with the same write-first bypass the core
//                          uses). Undefined by default.
//
// Timing: an instruction whose address is placed in PC at edge n is latched
// into IF/ID at n+1, computed into EX/WB at n+2 and written back at n+3.
// Operand reads bypass the WB write of the same cycle, so dependent
// instructions issue back-to-back without stalls.
// ---------------------------------------------------------------------------
module top_mips #(
    parameter int NB_ADDR    = 32,
    parameter int NB_INST    = 32,
    parameter int NB_DATA    = 32,
    parameter int NB_REG     = 5,
    parameter int IMEM_DEPTH = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic               i_write,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic [NB_ADDR-1:0] i_address,
    input  logic [NB_DATA-1:0] i_data_mem,
`ifdef MIPS_DEBUG_REGREAD_EN
    input  logic [NB_REG-1:0]  i_address_read_debug,
`endif
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_DATA-1:0] o_data_read_debug
);

    localparam int IDX_W    = $clog2(IMEM_DEPTH);
    localparam int NUM_REGS = 2 ** NB_REG;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NB_ADDR-1:0] pc_q;
    logic [NB_INST-1:0] imem [IMEM_DEPTH];
    logic [NB_INST-1:0] if_id_q;

    logic               ex_we_q;
    logic [NB_REG-1:0]  ex_dest_q;
    logic [NB_DATA-1:0] ex_result_q;

    logic [NB_DATA-1:0] regs [NUM_REGS];

    // Only the low index bits address the memory; upper bits wrap around.
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] write_idx;
    logic             unused_addr_bits;

    assign fetch_idx        = pc_q[IDX_W-1:0];
    assign write_idx        = i_address[IDX_W-1:0];
    assign unused_addr_bits = ^i_address[NB_ADDR-1:IDX_W];

    // A write-back actually happens this cycle. r0 is never written, so it
    // keeps its reset value of 0 for good.
    logic wb_commit;
    assign wb_commit = i_enable && ex_we_q && (ex_dest_q != '0);

    // -----------------------------------------------------------------------
    // IF: instruction memory and PC
    // -----------------------------------------------------------------------
    assign o_instruction = imem[fetch_idx];
    assign o_pc          = pc_q;

    // Debug writes ignore i_enable; the fetch in the same cycle reads the old
    // word because the write lands at the edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < IMEM_DEPTH; k++) begin
                imem[k] <= '0;
            end
        end else if (i_write) begin
            imem[write_idx] <= i_instruction;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q <= '0;
        end else if (i_write) begin
            pc_q <= i_pc;
        end else if (i_enable) begin
            pc_q <= pc_q + NB_ADDR'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            if_id_q <= '0;
        end else if (i_enable) begin
            if_id_q <= o_instruction;
        end
    end

    // -----------------------------------------------------------------------
    // ID/EX: decode, operand read with WB bypass, ALU
    // -----------------------------------------------------------------------
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [NB_REG-1:0] rs_idx;
    logic [NB_REG-1:0] rt_idx;
    logic [NB_REG-1:0] rd_idx;
    logic [15:0]       imm;

    assign opcode = if_id_q[31:26];
    assign rs_idx = if_id_q[25:21];
    assign rt_idx = if_id_q[20:16];
    assign rd_idx = if_id_q[15:11];
    assign shamt  = if_id_q[10:6];
    assign funct  = if_id_q[5:0];
    assign imm    = if_id_q[15:0];

    logic [NB_DATA-1:0] rs_val;
    logic [NB_DATA-1:0] rt_val;
    logic [NB_DATA-1:0] imm_sext;
    logic [NB_DATA-1:0] imm_zext;

    assign imm_sext = {{(NB_DATA-16){imm[15]}}, imm};
    assign imm_zext = {{(NB_DATA-16){1'b0}}, imm};

    // Write-first: the value retiring from EX/WB this cycle wins over the
    // stale register-file entry.
    always_comb begin
        rs_val = regs[rs_idx];
        if (wb_commit && (ex_dest_q == rs_idx)) begin
            rs_val = ex_result_q;
        end
    end

    always_comb begin
        rt_val = regs[rt_idx];
        if (wb_commit && (ex_dest_q == rt_idx)) begin
            rt_val = ex_result_q;
        end
    end

    logic               ex_we_d;
    logic [NB_REG-1:0]  ex_dest_d;
    logic [NB_DATA-1:0] ex_result_d;

    always_comb begin
        ex_we_d     = 1'b0;
        ex_dest_d   = '0;
        ex_result_d = '0;
        case (opcode)
            OP_RTYPE: begin
                ex_we_d   = 1'b1;
                ex_dest_d = rd_idx;
                case (funct)
                    F_ADD, F_ADDU: ex_result_d = rs_val + rt_val;
                    F_SUB, F_SUBU: ex_result_d = rs_val - rt_val;
                    F_AND:         ex_result_d = rs_val & rt_val;
                    F_OR:          ex_result_d = rs_val | rt_val;
                    F_XOR:         ex_result_d = rs_val ^ rt_val;
                    F_NOR:         ex_result_d = ~(rs_val | rt_val);
                    F_SLT:         ex_result_d = {{(NB_DATA-1){1'b0}},
                                                  ($signed(rs_val) < $signed(rt_val))};
                    F_SLTU:        ex_result_d = {{(NB_DATA-1){1'b0}},
                                                  (rs_val < rt_val)};
                    F_SLL:         ex_result_d = rt_val << shamt;
                    default:       ex_we_d     = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ex_we_d     = 1'b1;
                ex_dest_d   = rt_idx;
                ex_result_d = rs_val + imm_sext;
            end
            OP_ANDI: begin
                ex_we_d     = 1'b1;
                ex_dest_d   = rt_idx;
                ex_result_d = rs_val & imm_zext;
            end
            OP_ORI: begin
                ex_we_d     = 1'b1;
                ex_dest_d   = rt_idx;
                ex_result_d = rs_val | imm_zext;
            end
            OP_LUI: begin
                ex_we_d     = 1'b1;
                ex_dest_d   = rt_idx;
                ex_result_d = {imm, {(NB_DATA-16){1'b0}}};
            end
            OP_LW: begin
                // The address is computed by the external memory side; the
                // returned word is simply captured here.
                ex_we_d     = 1'b1;
                ex_dest_d   = rt_idx;
                ex_result_d = i_data_mem;
            end
            default: begin
                ex_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ex_we_q     <= 1'b0;
            ex_dest_q   <= '0;
            ex_result_q <= '0;
        end else if (i_enable) begin
            ex_we_q     <= ex_we_d;
            ex_dest_q   <= ex_dest_d;
            ex_result_q <= ex_result_d;
        end
    end

    // -----------------------------------------------------------------------
    // WB: register file
    // -----------------------------------------------------------------------
    // Reset loads reg[k] = k so programs have distinct operands to work with
    // without a preamble.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= NB_DATA'(k);
            end
        end else if (wb_commit) begin
            regs[ex_dest_q] <= ex_result_q;
        end
    end

`ifdef MIPS_DEBUG_REGREAD_EN
    always_comb begin
        o_data_read_debug = regs[i_address_read_debug];
        if (wb_commit && (ex_dest_q == i_address_read_debug)) begin
            o_data_read_debug = ex_result_q;
        end
    end
`else
    logic [NB_DATA-1:0] last_wb_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_wb_q <= '0;
        end else if (wb_commit) begin
            last_wb_q <= ex_result_q;
        end
    end

    assign o_data_read_debug = last_wb_q;
`endif

endmodule

// File: tb/tb_top_mips.sv
// ---------------------------------------------------------------------------
// tb_top_mips -- bench for top_mips (default build).
//
// An instruction-set reference model runs alongside the DUT: every enabled
// edge it executes, in program order, the word fetched on the previous enabled
// edge and schedules the resulting write-back value to become visible one
// enabled edge later. After every edge the bench compares o_pc,
// o_instruction and o_data_read_debug against the model, on top of
// table-driven single-instruction vectors and hand-written timing sequences.
// ---------------------------------------------------------------------------
module tb_top_mips;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic [31:0] i_pc;
    logic        i_write;
    logic [31:0] i_instruction;
    logic [31:0] i_address;
    logic [31:0] i_data_mem;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic [31:0] o_data_read_debug;

    int checks = 0;
    int errors = 0;

    top_mips dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_pc              (i_pc),
        .i_write           (i_write),
        .i_instruction     (i_instruction),
        .i_address         (i_address),
        .i_data_mem        (i_data_mem),
        .o_instruction     (o_instruction),
        .o_pc              (o_pc),
        .o_data_read_debug (o_data_read_debug)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_imem [64];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_debug;
    int          edge_cnt;
    logic [31:0] fetch_q[$];
    logic [31:0] exp_q[$];   // scoreboard: write-back values in order
    int          due_q[$];   // enabled-edge number at which each becomes visible

    task automatic model_reset();
        for (int k = 0; k < 64; k++) m_imem[k] = 32'h0;
        for (int k = 0; k < 32; k++) m_regs[k] = k;
        m_pc     = 32'h0;
        m_debug  = 32'h0;
        edge_cnt = 0;
        fetch_q.delete();
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic model_execute(input logic [31:0] w, input logic [31:0] dmem);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          dest;
        bit          writes;
        op     = w[31:26];
        fn     = w[5:0];
        a      = m_regs[w[25:21]];
        b      = m_regs[w[20:16]];
        writes = 1'b1;
        res    = 32'h0;
        dest   = w[20:16];
        case (op)
            6'h00: begin
                dest = w[15:11];
                case (fn)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << w[10:6];
                    default: writes = 1'b0;
                endcase
            end
            6'h08, 6'h09: res = a + {{16{w[15]}}, w[15:0]};
            6'h0C: res = a & {16'h0, w[15:0]};
            6'h0D: res = a | {16'h0, w[15:0]};
            6'h0F: res = {w[15:0], 16'h0};
            6'h23: res = dmem;
            default: writes = 1'b0;
        endcase
        if (writes && dest != 0) begin
            m_regs[dest] = res;
            exp_q.push_back(res);
            due_q.push_back(edge_cnt + 1);
        end
    endtask

    // One rising edge as seen by the architecture.
    task automatic model_edge();
        logic [31:0] fetched;
        logic [5:0]  widx;
        logic [5:0]  pidx;
        pidx    = m_pc[5:0];
        fetched = m_imem[pidx];
        if (i_enable) begin
            edge_cnt++;
            while (due_q.size() > 0 && due_q[0] == edge_cnt) begin
                m_debug = exp_q.pop_front();
                due_q.delete(0);
            end
            if (fetch_q.size() > 0) model_execute(fetch_q.pop_front(), i_data_mem);
            fetch_q.push_back(fetched);
        end
        if (i_write) begin
            widx = i_address[5:0];
            m_imem[widx] = i_instruction;
            m_pc = i_pc;
        end else if (i_enable) begin
            m_pc = m_pc + 32'd1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [5:0] pidx;
        @(posedge i_clk);
        if (i_reset) model_edge();
        #1;
        pidx = m_pc[5:0];
        check("pc", o_pc, m_pc);
        check("instruction", o_instruction, m_imem[pidx]);
        check("debug", o_data_read_debug, m_debug);
    endtask

    task automatic apply_reset();
        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_write  = 1'b0;
        model_reset();
        #2;
        check("reset_pc", o_pc, 32'h0);
        check("reset_instruction", o_instruction, 32'h0);
        check("reset_debug", o_data_read_debug, 32'h0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
    endtask

    // One debug-write edge; PC pinned to pc_val.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] word,
                              input logic [31:0] pc_val);
        i_write       = 1'b1;
        i_address     = addr;
        i_instruction = word;
        i_pc          = pc_val;
        tick();
        i_write = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] functs [12];
        logic [5:0] ops [8];
        logic [31:0] w;
        int kind;
        functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                   6'h2A, 6'h2B, 6'h00, 6'h08};
        ops    = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h04, 6'h2B};
        kind   = $urandom_range(0, 9);
        w      = $urandom;
        if (kind <= 4) begin
            w[31:26] = 6'h00;
            w[5:0]   = functs[$urandom_range(0, 11)];
        end else if (kind <= 8) begin
            w[31:26] = ops[$urandom_range(0, 7)];
        end
        return w;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] dmem;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- main test ----------------
    initial begin
        i_reset       = 1'b0;
        i_enable      = 1'b0;
        i_write       = 1'b0;
        i_pc          = 32'h0;
        i_instruction = 32'h0;
        i_address     = 32'h0;
        i_data_mem    = 32'h0;
        model_reset();

        // Single-instruction vectors, all from reset register state reg[k]=k.
        vecs[0]  = '{"add",      32'h00231020, 32'h0, 32'h00000004};
        vecs[1]  = '{"sub",      32'h00232022, 32'h0, 32'hFFFFFFFE};
        vecs[2]  = '{"and",      32'h03E62024, 32'h0, 32'h00000006};
        vecs[3]  = '{"or",       32'h01072025, 32'h0, 32'h0000000F};
        vecs[4]  = '{"xor",      32'h03E52026, 32'h0, 32'h0000001A};
        vecs[5]  = '{"nor",      32'h00002027, 32'h0, 32'hFFFFFFFF};
        vecs[6]  = '{"slt",      32'h0022202A, 32'h0, 32'h00000001};
        vecs[7]  = '{"sll",      32'h00032100, 32'h0, 32'h00000030};
        vecs[8]  = '{"addi_neg", 32'h2024FFFE, 32'h0, 32'hFFFFFFFF};
        vecs[9]  = '{"andi",     32'h33E4FFF5, 32'h0, 32'h00000015};
        vecs[10] = '{"ori_zext", 32'h36048001, 32'h0, 32'h00008011};
        vecs[11] = '{"lui",      32'h3C04ABCD, 32'h0, 32'hABCD0000};
        vecs[12] = '{"lw",       32'h8C090000, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[13] = '{"sltu",     32'h0001202B, 32'h0, 32'h00000001};
        vecs[14] = '{"bad_op",   32'h08000000, 32'h0, 32'h00000000};
        vecs[15] = '{"r0_write", 32'h00210020, 32'h0, 32'h00000000};

        for (int i = 0; i < 16; i++) begin
            apply_reset();
            i_enable   = 1'b1;
            i_data_mem = vecs[i].dmem;
            write_word(32'd0, vecs[i].instr, 32'd0);
            repeat (3) tick();
            check(vecs[i].name, o_data_read_debug, vecs[i].exp);
        end

        // ADD load/execute with i_write held high.
        apply_reset();
        i_enable      = 1'b1;
        i_write       = 1'b1;
        i_address     = 32'd1;
        i_instruction = 32'h00231020;
        i_pc          = 32'd1;
        repeat (4) tick();
        check("hold_write_pc", o_pc, 32'd1);
        check("hold_write_instr", o_instruction, 32'h00231020);
        check("hold_write_result", o_data_read_debug, 32'd4);
        tick();
        check("hold_write_stable", o_data_read_debug, 32'd4);
        i_write = 1'b0;

        // Dependency chain: 7, 14, 13 on consecutive edges.
        apply_reset();
        i_enable = 1'b1;
        write_word(32'd0, 32'h20050007, 32'd0);
        write_word(32'd1, 32'h00A53020, 32'd0);
        write_word(32'd2, 32'h00C13822, 32'd0);
        repeat (3) tick();
        check("chain_addi", o_data_read_debug, 32'd7);
        tick();
        check("chain_add", o_data_read_debug, 32'd14);
        tick();
        check("chain_sub", o_data_read_debug, 32'd13);

        // Same chain with a 5-cycle freeze after the first commit.
        apply_reset();
        i_enable = 1'b1;
        write_word(32'd0, 32'h20050007, 32'd0);
        write_word(32'd1, 32'h00A53020, 32'd0);
        write_word(32'd2, 32'h00C13822, 32'd0);
        repeat (3) tick();
        check("freeze_first", o_data_read_debug, 32'd7);
        i_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("freeze_pc", o_pc, 32'd3);
            check("freeze_debug", o_data_read_debug, 32'd7);
        end
        i_enable = 1'b1;
        tick();
        check("resume_add", o_data_read_debug, 32'd14);
        tick();
        check("resume_sub", o_data_read_debug, 32'd13);

        // r0 discard, LW, and r0 still reading 0 afterwards.
        apply_reset();
        i_enable   = 1'b1;
        i_data_mem = 32'hDEADBEEF;
        write_word(32'd0, 32'h20050007, 32'd0);
        write_word(32'd1, 32'h00210020, 32'd0);
        write_word(32'd2, 32'h8C090000, 32'd0);
        write_word(32'd3, 32'h00015020, 32'd0);
        repeat (3) tick();
        check("r0_seq_addi", o_data_read_debug, 32'd7);
        tick();
        check("r0_seq_discard", o_data_read_debug, 32'd7);
        tick();
        check("r0_seq_lw", o_data_read_debug, 32'hDEADBEEF);
        tick();
        check("r0_seq_read0", o_data_read_debug, 32'd1);

        // Wrap-around of PC and debug write address.
        apply_reset();
        i_enable = 1'b1;
        write_word(32'd0, 32'h3C041234, 32'd0);
        write_word(32'd69, 32'h3C045678, 32'd5);   // lands in imem[5]
        check("wrap_waddr", o_instruction, 32'h3C045678);
        write_word(32'd63, 32'h00000000, 32'd63);
        check("wrap_pc63", o_pc, 32'd63);
        tick();
        check("wrap_pc64", o_pc, 32'd64);
        check("wrap_fetch0", o_instruction, 32'h3C041234);

        // Randomized run against the reference model, with one mid-run reset.
        apply_reset();
        i_enable = 1'b1;
        for (int a = 0; a < 64; a++) write_word(a, rand_instr(), 32'd0);
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                apply_reset();
                i_enable = 1'b1;
                for (int a = 0; a < 32; a++) write_word(a, rand_instr(), 32'd0);
            end
            i_enable      = ($urandom_range(0, 9) != 0);
            i_write       = ($urandom_range(0, 19) == 0);
            i_address     = $urandom;
            i_instruction = rand_instr();
            i_pc          = $urandom_range(0, 127);
            i_data_mem    = $urandom;
            tick();
        end
        i_write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
